// File: rtl/mul_sequencer_pkg.sv
// rtl/mul_sequencer_pkg.sv - shared widths, state encoding and helpers for the shift-add multiplier
package mul_sequencer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 5;
  localparam int ITERATIONS = 32;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_SIGN = 2'd2;
  localparam state_t S_DONE = 2'd3;

  // 0x80000000 maps to itself and is then treated as an unsigned magnitude
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic is_signed,
                                                      input logic [DATA_WIDTH-1:0] x);
    return (is_signed && x[DATA_WIDTH-1]) ? (~x + DATA_WIDTH'(1)) : x;
  endfunction
endpackage

// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - EX-stage request/result bundle for the multiplier sequencer
interface mul_sequencer_if;
  import mul_sequencer_pkg::*;

  logic                  start;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  busy;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (output start, signed_op, operand_a, operand_b,
                  input  busy, stall, done, hi, lo);
  modport slave  (input  start, signed_op, operand_a, operand_b,
                  output busy, stall, done, hi, lo);
endinterface

// File: rtl/mul_seq_datapath.sv
// rtl/mul_seq_datapath.sv - operand latches, 33-bit add/shift accumulator and 64-bit sign fixup
module mul_seq_datapath
  import mul_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  finish_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  logic [DATA_WIDTH-1:0]   mcand_q, p_hi_q, p_lo_q, hi_q, lo_q;
  logic                    neg_q;
  logic [DATA_WIDTH:0]     sum;
  logic [2*DATA_WIDTH-1:0] prod;

  // carry-out lands in the top bit and is shifted back into p_hi
  assign sum  = p_lo_q[0] ? ({1'b0, p_hi_q} + {1'b0, mcand_q}) : {1'b0, p_hi_q};
  assign prod = {p_hi_q, p_lo_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (load_i) begin
      mcand_q <= magnitude(signed_i, operand_a_i);
      p_hi_q  <= '0;
      p_lo_q  <= magnitude(signed_i, operand_b_i);
      neg_q   <= signed_i & (operand_a_i[DATA_WIDTH-1] ^ operand_b_i[DATA_WIDTH-1]);
    end else if (step_i) begin
      p_hi_q  <= sum[DATA_WIDTH:1];
      p_lo_q  <= {sum[0], p_lo_q[DATA_WIDTH-1:1]};
    end else if (finish_i) begin
      {hi_q, lo_q} <= neg_q ? (~prod + (2*DATA_WIDTH)'(1)) : prod;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative mult/multu controller raising Stall while the product is formed
module mul_sequencer
  import mul_sequencer_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  mul_sequencer_if.slave bus
);
  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  busy_q, done_q;
  logic                  load, step, finish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(ITERATIONS - 1)) state_d = S_SIGN;
      end
      S_SIGN: begin
        finish  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_SIGN);
    end
  end

  // Stall drops in DONE so a dependent mfhi/mflo issues as Hi/Lo become valid
  assign bus.stall = bus.start | (state_q == S_RUN) | (state_q == S_SIGN);
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  mul_seq_datapath u_datapath (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load),
    .step_i      (step),
    .finish_i    (finish),
    .signed_i    (bus.signed_op),
    .operand_a_i (bus.operand_a),
    .operand_b_i (bus.operand_b),
    .hi_o        (bus.hi),
    .lo_o        (bus.lo)
  );
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - vector table and corner-case sequences for mul_sequencer
module tb_mul_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [63:0] exp_q[$];

  mul_sequencer_if bus ();
  mul_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        toggle;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // caller is at a negedge; issues Start for exactly one edge
  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input bit push);
    bus.start = 1'b1;
    bus.signed_op = sgn;
    bus.operand_a = a;
    bus.operand_b = b;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic finish_op(input bit toggle, input bit inject);
    int edges = 0;
    bit got = 0;
    logic [63:0] e;
    while (edges < 40 && !got) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (bus.done) got = 1;
      else chk("stall_in_flight", bus.stall, 1);
      if (toggle) begin
        bus.operand_a = ~bus.operand_a;
        bus.signed_op = ~bus.signed_op;
      end
      if (inject && edges == 5) begin
        bus.start = 1'b1; bus.signed_op = 1'b0;
        bus.operand_a = 32'd2; bus.operand_b = 32'd2;
      end
      if (inject && edges == 6) bus.start = 1'b0;
    end
    chk("done_seen", 64'(got), 1);
    chk("latency_edges", 64'(edges), 33);
    chk("stall_in_done", bus.stall, 0);
    chk("busy_in_done", bus.busy, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hi", bus.hi, e[63:32]);
      chk("lo", bus.lo, e[31:0]);
    end else chk("scoreboard_nonempty", 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{1'b0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1};
    vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[4] = '{1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[6] = '{1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[7] = '{1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b1};

    bus.start = 1'b0; bus.signed_op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);

    // back-to-back: each Start lands in the IDLE cycle right after DONE
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 1);
      finish_op(vecs[i].toggle, 0);
    end

    start_op(1'b0, 32'd7, 32'd6, 64'h2A, 1);
    finish_op(0, 1);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("reject_extra_done", 64'(pulses), 0);
    chk("hold_hi", bus.hi, 0);
    chk("hold_lo", bus.lo, 64'h2A);

    start_op(1'b0, 32'd5, 32'd5, 64'd0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_hi", bus.hi, 0);
    chk("mid_rst_lo", bus.lo, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    start_op(1'b0, 32'd3, 32'd3, 64'd9, 1);
    finish_op(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Iterative shift-add multiplier controller for the MIPS pipeline's EX stage. It executes mult and multu over 32 cycles and writes the 64-bit product into the HI/LO registers.
- While an operation is in flight, it raises Stall to the hazard/pipeline-control logic so later instructions freeze.
- It replaces a single-cycle 32x32 multiplier on the critical path with one small adder that is reused every cycle.

Parameters:
- DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH.
- CNT_WIDTH, 5, iteration counter width; must satisfy 2**CNT_WIDTH == DATA_WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  one-cycle request from the EX stage (mult/multu decoded).
- Signed  input  1  1 = mult (two's complement), 0 = multu; sampled with Start.
- OperandA  input  DATA_WIDTH  multiplicand (rs); sampled with Start.
- OperandB  input  DATA_WIDTH  multiplier (rt); sampled with Start.
- Busy  output  1  registered; high in RUN, SIGN and DONE.
- Stall  output  1  combinational: Start OR (state is RUN or SIGN).
- Done  output  1  registered; high for exactly one cycle when Hi/Lo are updated.
- Hi  output  DATA_WIDTH  upper product word; holds until the next completion.
- Lo  output  DATA_WIDTH  lower product word; holds until the next completion.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - Busy = 0, Done = 0, Hi = 0, Lo = 0.
  - Counter, accumulator and latched operands are cleared.
  - An operation in flight is abandoned; no partial result reaches Hi/Lo.
- FSM states: IDLE, RUN, SIGN, DONE.
- IDLE:
  - If Start = 1 at an edge, latch Signed.
  - Latch |OperandA| and |OperandB| (magnitude only when Signed = 1, raw value otherwise).
  - Latch neg = Signed & (A[31] ^ B[31]).
  - Clear the 64-bit accumulator {P_hi, P_lo}, load P_lo with the multiplier magnitude, set counter = 0, go to RUN.
- RUN, each edge:
  - If P_lo[0] = 1, form sum = {carry, P_hi + mcand} (33 bits); otherwise sum = {0, P_hi}.
  - {P_hi, P_lo} <= {sum, P_lo} >> 1.
  - Counter increments. At the edge where counter == 31 (the 32nd iteration), go to SIGN.
- SIGN, one edge:
  - If neg = 1, {Hi, Lo} <= two's-complement negation of {P_hi, P_lo}; otherwise {Hi, Lo} <= {P_hi, P_lo}.
  - Done <= 1. Go to DONE.
- DONE, one cycle:
  - Done = 1; Hi/Lo are valid.
  - Next edge: Done <= 0, go to IDLE.
- Latency: Start sampled at edge k; Done is high in the cycle after edge k+33; Hi/Lo are stable from that cycle on.
- Stall is high from the Start cycle through the SIGN cycle and low in DONE, so the dependent mfhi/mflo issues the cycle Hi/Lo become valid.
- Start while Busy (RUN, SIGN or DONE) is ignored; no queuing. Upstream must hold the request while Stall = 1.
- Operand or Signed changes after the Start edge have no effect.
- Width rules:
  - The magnitude of 0x80000000 is 0x80000000 and is handled as unsigned 32-bit.
  - The adder carry-out must be kept.
  - Negation is performed over all 64 bits.

Decomposition:
- Shared package: state encoding constants (S_IDLE=2'd0, S_RUN=2'd1, S_SIGN=2'd2, S_DONE=2'd3), DATA_WIDTH, CNT_WIDTH, ITERATIONS=32.
- Natural sub-module mul_seq_datapath: owns the operand/accumulator registers, 33-bit adder, shifter and 64-bit negate.
  - Control inputs: load, step, finish.
  - Top level keeps the FSM, counter, Stall, Busy and Done.

Test Plan:
- Unsigned basic: Start, Signed=0, A=7, B=6 -> Done exactly 34 cycles after the Start edge; Hi=0x00000000, Lo=0x0000002A; Stall high for 33 cycles, then low.
- Unsigned max: Signed=0, A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- Signed mix:
  - Signed=1, A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - Signed=1, A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
- Busy rejection: second Start with A=2, B=2 pulsed during RUN -> ignored; first result unchanged; exactly one Done pulse; Hi/Lo hold after Done until the next Start completes.
- Reset mid-operation: assert Reset at RUN iteration 10 after a prior result Hi/Lo=0/0x2A -> immediately Busy=0, Stall=0 (Start low), Done=0, Hi=Lo=0. After release, a new 3*3 returns Lo=9 in 34 cycles.
- Back-to-back: Start asserted in the cycle after the Done cycle (state IDLE) -> accepted; second result correct; operand changes during RUN (A toggled every cycle) do not affect the product.
